// File: rtl/dmac_pkg.sv
// Shared definitions for the DMA channel arbiter: channel geometry,
// arbiter FSM encoding and a one-hot helper.
package dmac_pkg;

  localparam int CH_NUM  = 16;
  localparam int PRI_W   = 2;
  localparam int CH_ID_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ARB  = 2'b01,
    GNT  = 2'b10
  } arb_state_e;

  function automatic logic [CH_NUM-1:0] id_to_onehot(input logic [CH_ID_W-1:0] id);
    logic [CH_NUM-1:0] one;
    one = {{(CH_NUM-1){1'b0}}, 1'b1};
    return one << id;
  endfunction

endpackage

// File: rtl/dmac_rr_pick.sv
// Round-robin picker: first set bit of mask, scanning upward from start
// with wrap-around.
module dmac_rr_pick
  import dmac_pkg::*;
(
  input  logic [CH_NUM-1:0]  mask,
  input  logic [CH_ID_W-1:0] start,
  output logic               found,
  output logic [CH_ID_W-1:0] winner
);

  // Priority scan from start; the first hit freezes the winner.
  always_comb begin
    logic [CH_ID_W-1:0] idx;
    logic               hit;
    found  = 1'b0;
    winner = {CH_ID_W{1'b0}};
    idx    = {CH_ID_W{1'b0}};
    hit    = 1'b0;
    for (int i = 0; i < CH_NUM; i++) begin
      idx    = start + CH_ID_W'(i);
      hit    = mask[idx] & ~found;
      winner = hit ? idx : winner;
      found  = found | hit;
    end
  end

endmodule

// File: rtl/dmac_ch_arb.sv
// DMA channel arbiter: grants one requesting channel at a time to the bus
// master, highest priority first, round-robin among equal priorities.
module dmac_ch_arb #(
  parameter int CH_NUM = 16,
  parameter int PRI_W  = 2
) (
  input  logic                         hclk,
  input  logic                         hrst_n,
  input  logic                         gbc_chnc_dmacen,
  input  logic [CH_NUM-1:0]            chn_arb_req,
  input  logic [CH_NUM*PRI_W-1:0]      chn_arb_pri,
  input  logic                         mst_arb_done,
  output logic [CH_NUM-1:0]            arb_chn_gnt,
  output logic                         arb_mst_vld,
  output logic [dmac_pkg::CH_ID_W-1:0] arb_mst_chid
);
  import dmac_pkg::*;

  arb_state_e         state_r;
  arb_state_e         next_state_s;
  logic [CH_ID_W-1:0] last_id_r;
  logic [CH_ID_W-1:0] start_id_s;
  logic [PRI_W-1:0]   top_pri_s;
  logic [CH_NUM-1:0]  top_mask_s;
  logic               pick_found_s;
  logic [CH_ID_W-1:0] pick_id_s;
  logic               load_gnt_s;
  logic               clr_gnt_s;

  // Highest requested priority, then the requesters sitting at that level.
  always_comb begin
    logic [PRI_W-1:0] pri_v;
    top_pri_s  = {PRI_W{1'b0}};
    top_mask_s = {CH_NUM{1'b0}};
    pri_v      = {PRI_W{1'b0}};
    for (int i = 0; i < CH_NUM; i++) begin
      pri_v     = chn_arb_pri[i*PRI_W +: PRI_W];
      top_pri_s = (chn_arb_req[i] && (pri_v > top_pri_s)) ? pri_v : top_pri_s;
    end
    for (int i = 0; i < CH_NUM; i++) begin
      pri_v         = chn_arb_pri[i*PRI_W +: PRI_W];
      top_mask_s[i] = chn_arb_req[i] && (pri_v == top_pri_s);
    end
  end

  assign start_id_s = last_id_r + 4'd1;

  dmac_rr_pick u_rr_pick (
    .mask   (top_mask_s),
    .start  (start_id_s),
    .found  (pick_found_s),
    .winner (pick_id_s)
  );

  // Next-state logic; done outside GNT is deliberately ignored.
  always_comb begin
    next_state_s = state_r;
    load_gnt_s   = 1'b0;
    clr_gnt_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (gbc_chnc_dmacen && (|chn_arb_req)) begin
          next_state_s = ARB;
        end else begin
          next_state_s = IDLE;
        end
      end
      ARB: begin
        if (gbc_chnc_dmacen && pick_found_s) begin
          next_state_s = GNT;
          load_gnt_s   = 1'b1;
        end else begin
          next_state_s = IDLE;
        end
      end
      GNT: begin
        if (mst_arb_done) begin
          next_state_s = IDLE;
          clr_gnt_s    = 1'b1;
        end else begin
          next_state_s = GNT;
        end
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge hclk or negedge hrst_n) begin
    if (!hrst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Grant outputs and round-robin pointer; pointer advances on completion.
  always_ff @(posedge hclk or negedge hrst_n) begin
    if (!hrst_n) begin
      arb_chn_gnt  <= {CH_NUM{1'b0}};
      arb_mst_vld  <= 1'b0;
      arb_mst_chid <= {CH_ID_W{1'b0}};
      last_id_r    <= 4'd15;
    end else if (load_gnt_s) begin
      arb_chn_gnt  <= id_to_onehot(pick_id_s);
      arb_mst_vld  <= 1'b1;
      arb_mst_chid <= pick_id_s;
    end else if (clr_gnt_s) begin
      arb_chn_gnt  <= {CH_NUM{1'b0}};
      arb_mst_vld  <= 1'b0;
      arb_mst_chid <= {CH_ID_W{1'b0}};
      last_id_r    <= arb_mst_chid;
    end else begin
      arb_chn_gnt  <= arb_chn_gnt;
      arb_mst_vld  <= arb_mst_vld;
      arb_mst_chid <= arb_mst_chid;
    end
  end

endmodule
